// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word at a time over req/gnt/rvalid, presents it to decode.
// Latency: gnt cycle + memory response latency + 1 cycle to VALID + 1 cycle back to REQ (best case 3 cycles/instr).
// Backpressure: InstrF/PCF held while InstrReady=0; only one memory request outstanding; HALT freezes until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        Fault,
    output logic [1:0]  FaultCause
);

    // Counter only needs to reach TIMEOUT-1; a zero TIMEOUT disables the check entirely.
    localparam int unsigned    CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic           TO_EN   = (TIMEOUT != 0);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               vld_q, vld_d;
    logic               fault_q, fault_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pc_plus4;
    logic [31:0]        next_pc;

    assign pc_plus4 = pc_q + 32'd4;
    // Redirect selection is only acted upon in the VALID consume cycle.
    assign next_pc  = PCSrc ? PCTarget : pc_plus4;

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign InstrF     = instr_q;
    assign PCF        = pc_q;
    assign PCPlus4F   = pc_plus4;
    assign InstrValid = vld_q;
    assign Fault      = fault_q;
    assign FaultCause = cause_q;

    // State register and datapath registers; reset may land in any state, even mid-request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and register updates; everything holds by default, which also freezes HALT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        fault_d = fault_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_REQ: begin
                // rvalid here can only be a leftover from an aborted request, so it is dropped.
                if (imem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A response arriving on the threshold cycle still wins over the timeout.
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    vld_d   = 1'b1;
                    state_d = S_VALID;
                end else if (TO_EN && (cnt_q == CNT_MAX)) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VALID: begin
                if (InstrReady) begin
                    vld_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        // Keep the PC of the instruction that produced the bad target.
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch front end for the RISC-V core. Owns the PC, requests instruction words from instruction memory over a req/gnt/rvalid handshake, and presents one instruction at a time to the decode/control path.
- Consumes PCSrc and PCTarget coming back from control/datapath to choose the next PC.
- One outstanding memory request at a time. Latches a sticky fault on a misaligned target or a memory timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum cycles in WAIT without rvalid before a timeout fault; 0 disables the timeout.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  request valid to instruction memory.
imem_addr  output  32  request word address; equals PCF while imem_req=1.
imem_gnt  input  1  memory accepts the request in this cycle.
imem_rvalid  input  1  response data valid.
imem_rdata  input  32  response instruction word.
InstrF  output  32  fetched instruction presented to decode.
PCF  output  32  PC of InstrF.
PCPlus4F  output  32  PCF + 4, modulo 2^32.
InstrValid  output  1  InstrF/PCF are valid.
InstrReady  input  1  core consumes InstrF this cycle.
PCSrc  input  1  take PCTarget as next PC; sampled only on the consume handshake.
PCTarget  input  32  branch/jump target.
Fault  output  1  sticky fault flag.
FaultCause  output  2  01 = misaligned target, 10 = timeout, 00 = none.

Behaviour:
- Reset (async, any state, including mid-request): state=REQ, PCF=RESET_PC, InstrF=0, InstrValid=0, Fault=0, FaultCause=00, timeout counter=0. imem_req=1 in the first cycle after reset deasserts.
- FSM states: REQ, WAIT, VALID, HALT.
- REQ:
  - imem_req=1, imem_addr=PCF.
  - imem_gnt=1 -> WAIT and clear the counter.
  - imem_rvalid is ignored in REQ. Stale responses are dropped.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> InstrF<=imem_rdata, InstrValid<=1, go to VALID.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no rvalid -> Fault<=1, FaultCause<=10, go to HALT.
  - rvalid in the same cycle as the timeout threshold: rvalid wins, no fault.
- VALID:
  - InstrValid=1. InstrF and PCF are held stable while InstrReady=0.
  - On InstrReady=1, next = PCSrc ? PCTarget : PCPlus4F.
  - If next[1:0]!=00: Fault<=1, FaultCause<=01, InstrValid<=0, go to HALT; PCF is not updated.
  - Else PCF<=next, InstrValid<=0, go to REQ.
- HALT: imem_req=0, InstrValid=0. Outputs are frozen until reset; only reset exits HALT.
- Latency: gnt cycle + response latency + 1 cycle to VALID + 1 cycle back to REQ. Best case is one instruction per 3 cycles (gnt immediate, rvalid the cycle after gnt, ready immediate).
- Arithmetic: PCPlus4F is combinational from PCF. 32'hFFFF_FFFC + 4 wraps to 0, with no fault.
- PCSrc and PCTarget are don't-care outside the VALID consume cycle.
- imem_addr is always PCF. Only imem_req qualifies it.

Test Plan:
- Reset release, memory with gnt immediate and rvalid 1 cycle later returning 32'h00500093 -> imem_addr=0; InstrValid rises 2 cycles after the gnt cycle; InstrF=32'h00500093, PCF=0, PCPlus4F=4.
- Sequential fetch: three instructions consumed with InstrReady=1, PCSrc=0 -> requests at 0, 4, 8; InstrF held unchanged during an inserted 3-cycle InstrReady=0 stall.
- Redirect: consume at PCF=8 with PCSrc=1, PCTarget=32'h40 -> next request address 32'h40; PCF=32'h40 on the next VALID.
- Misaligned: PCSrc=1, PCTarget=32'h42 -> Fault=1, FaultCause=01, imem_req stays 0 for 20 cycles, PCF stays at the old value.
- Timeout (TIMEOUT=16): gnt given, rvalid withheld -> Fault=1 and FaultCause=10 after 16 WAIT cycles. Repeat with rvalid on the 16th cycle -> no fault, InstrValid=1.
- Async reset asserted mid-WAIT, stale rvalid arriving in the cycle after release -> rvalid ignored, fresh request at RESET_PC, Fault=0. Also wrap case: PCF=32'hFFFF_FFFC, sequential consume -> next request address 0.
